// File: rtl/l2_prefetch_assoc_if.sv
// l2_prefetch_assoc_if: CPU read, fill/invalidate write and flush bus of the associative L2 prefetch buffer
interface l2_prefetch_assoc_if #(
    parameter int ADDR_W = 27,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   rda;
    logic                rden;
    logic [DATA_W-1:0]   rdd;
    logic                match;
    logic [ADDR_W-1:0]   wra;
    logic [DATA_W-1:0]   wrd;
    logic                wr;
    logic [DATA_W/8-1:0] wrm;
    logic                clr;
    logic                flush;
    logic                busy;
    modport master (output rda, rden, wra, wrd, wr, wrm, clr, flush, input rdd, match, busy);
    modport slave  (input rda, rden, wra, wrd, wr, wrm, clr, flush, output rdd, match, busy);
endinterface

// File: rtl/l2_prefetch_assoc.sv
// l2_prefetch_assoc: N-way set-associative word prefetch buffer with round-robin replacement and flush sweep
module l2_prefetch_assoc #(
    parameter int ADDR_W  = 27,
    parameter int INDEX_W = 5,
    parameter int WAYS    = 2,
    parameter int DATA_W  = 32
) (
    input logic              clk_i,
    input logic              rst_ni,
    l2_prefetch_assoc_if.slave bus
);
    localparam int SETS  = 1 << INDEX_W;
    localparam int TAG_W = ADDR_W - INDEX_W;
    localparam int MW    = DATA_W / 8;
    localparam int RR_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SWEEP = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [INDEX_W-1:0] cnt_q, cnt_d;
    logic [TAG_W-1:0]   tag_q   [SETS][WAYS];
    logic [DATA_W-1:0]  data_q  [SETS][WAYS];
    logic [WAYS-1:0]    valid_q [SETS];
    logic [RR_W-1:0]    rr_q    [SETS];
    logic [DATA_W-1:0]  rdd_q, rdd_d;
    logic               match_q, match_d;

    logic               busy;
    logic [INDEX_W-1:0] rd_idx, wr_idx;
    logic [TAG_W-1:0]   rd_tag, wr_tag;
    logic [WAYS-1:0]    rd_hit, wr_hit;
    logic [DATA_W-1:0]  rd_word;
    logic [RR_W-1:0]    victim, rr_next;
    logic               all_valid, upd, alloc, inv, rd_ok;

    assign busy      = state_q == SWEEP;
    assign rd_idx    = bus.rda[INDEX_W-1:0];
    assign rd_tag    = bus.rda[ADDR_W-1:INDEX_W];
    assign wr_idx    = bus.wra[INDEX_W-1:0];
    assign wr_tag    = bus.wra[ADDR_W-1:INDEX_W];
    assign bus.busy  = busy;
    assign bus.rdd   = rdd_q;
    assign bus.match = match_q;

    // Tag compare of every way for both ports; hits are one-hot so the read word is an OR-mux
    always_comb begin
        rd_hit  = '0;
        wr_hit  = '0;
        rd_word = '0;
        for (int w = 0; w < WAYS; w++) begin
            rd_hit[w] = valid_q[rd_idx][w] && tag_q[rd_idx][w] == rd_tag;
            wr_hit[w] = valid_q[wr_idx][w] && tag_q[wr_idx][w] == wr_tag;
            rd_word   = rd_word | (rd_hit[w] ? data_q[rd_idx][w] : '0);
        end
    end

    // Victim is the lowest invalid way, falling back to the set's round-robin pointer
    always_comb begin
        victim = rr_q[wr_idx];
        for (int w = WAYS - 1; w >= 0; w--)
            if (!valid_q[wr_idx][w]) victim = RR_W'(w);
        all_valid = &valid_q[wr_idx];
        rr_next   = (WAYS == 1) ? '0 : rr_q[wr_idx] + 1'b1;
        upd       = !busy && bus.wr && !bus.clr && |wr_hit;
        alloc     = !busy && bus.wr && !bus.clr && !(|wr_hit) && &bus.wrm;
        inv       = !busy && bus.wr && bus.clr && |wr_hit;
    end

    // Sweep walks every set once, then waits in IDLE for a flush request
    always_comb begin
        state_d = busy ? (&cnt_q ? IDLE : SWEEP) : (bus.flush ? SWEEP : IDLE);
        cnt_d   = busy ? cnt_q + 1'b1 : '0;
    end

    // Reset restarts the sweep from set 0
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= SWEEP;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Valid bits and replacement pointers: cleared by the sweep, else updated by invalidate/allocate
    always_ff @(posedge clk_i) begin
        if (busy) begin
            valid_q[cnt_q] <= '0;
            rr_q[cnt_q]    <= '0;
        end else if (inv) begin
            valid_q[wr_idx] <= valid_q[wr_idx] & ~wr_hit;
        end else if (alloc) begin
            valid_q[wr_idx][victim] <= 1'b1;
            if (all_valid) rr_q[wr_idx] <= rr_next;
        end
    end

    // Tag/data storage: full-line fill on allocate, byte-lane merge on write hit
    always_ff @(posedge clk_i) begin
        for (int w = 0; w < WAYS; w++) begin
            if (alloc && victim == RR_W'(w)) begin
                tag_q[wr_idx][w]  <= wr_tag;
                data_q[wr_idx][w] <= bus.wrd;
            end else if (upd && wr_hit[w]) begin
                for (int b = 0; b < MW; b++)
                    if (bus.wrm[b]) data_q[wr_idx][w][8*b +: 8] <= bus.wrd[8*b +: 8];
            end
        end
    end

    // Read result: misses keep the old word, a sweep forces a miss
    always_comb begin
        rd_ok   = bus.rden && !busy && $onehot(rd_hit);
        match_d = bus.rden ? rd_ok : match_q;
        rdd_d   = rd_ok ? rd_word : rdd_q;
    end

    // Registered read port, sampled before any same-edge write lands
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rdd_q   <= '0;
            match_q <= 1'b0;
        end else begin
            rdd_q   <= rdd_d;
            match_q <= match_d;
        end
    end
endmodule

// File: tb/tb_l2_prefetch_assoc.sv
// tb_l2_prefetch_assoc: scenario tasks with a read-result scoreboard for the associative prefetch buffer
module tb_l2_prefetch_assoc;
    typedef struct {
        logic        m;
        logic [31:0] d;
        logic        cd;
        int          id;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic pend  = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   rid    = 0;
    exp_t sb[$];
    exp_t e;

    always #5 clk = ~clk;

    l2_prefetch_assoc_if #(.ADDR_W(27), .DATA_W(32)) bus();

    l2_prefetch_assoc #(.ADDR_W(27), .INDEX_W(5), .WAYS(2), .DATA_W(32)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    // A read sampled at a rising edge has its result ready by the following falling edge
    always @(posedge clk) pend <= bus.rden;

    always @(negedge clk) begin
        if (pend) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_read: got match=%0b rdd=%h with nothing expected", bus.match, bus.rdd);
            end else begin
                e = sb.pop_front();
                if (bus.match !== e.m || (e.cd && bus.rdd !== e.d)) begin
                    errors++;
                    $display("FAIL read#%0d: got match=%0b rdd=%h, expected match=%0b rdd=%h%s",
                             e.id, bus.match, bus.rdd, e.m, e.d, e.cd ? "" : " (data unchecked)");
                end
            end
        end
    end

    task automatic wr(input logic [26:0] a, input logic [31:0] d, input logic [3:0] m, input logic c);
        bus.wr = 1'b1; bus.wra = a; bus.wrd = d; bus.wrm = m; bus.clr = c;
        @(negedge clk);
        bus.wr = 1'b0; bus.clr = 1'b0;
    endtask

    task automatic rd(input logic [26:0] a, input logic em, input logic [31:0] ed, input logic cd);
        bus.rden = 1'b1; bus.rda = a;
        sb.push_back('{m: em, d: ed, cd: cd, id: rid});
        rid++;
        @(negedge clk);
        bus.rden = 1'b0;
    endtask

    task automatic count_busy(input string name);
        int n;
        n = 0;
        while (bus.busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != 32) begin
            errors++;
            $display("FAIL %s_busy_cycles: got %0d, expected 32", name, n);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1 || bus.match !== 1'b0 || bus.rdd !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: busy=%0b match=%0b rdd=%h, expected 1 0 00000000", bus.busy, bus.match, bus.rdd);
        end
        rst_n = 1'b1;
        count_busy("reset");
        rd(27'h0000000, 1'b0, 32'h0, 1'b1);
        rd(27'h7FFFFFF, 1'b0, 32'h0, 1'b1);
        rd(27'h0000123, 1'b0, 32'h0, 1'b1);
    endtask

    task automatic test_alloc_hit;
        wr(27'h0000123, 32'hDEADBEEF, 4'hF, 1'b0);
        rd(27'h0000123, 1'b1, 32'hDEADBEEF, 1'b1);
        rd(27'h0000143, 1'b0, 32'hDEADBEEF, 1'b1);
    endtask

    task automatic test_partial;
        wr(27'h0000123, 32'h00005A5A, 4'b0011, 1'b0);
        rd(27'h0000123, 1'b1, 32'hDEAD5A5A, 1'b1);
        wr(27'h0000123, 32'h77000000, 4'b1000, 1'b0);
        rd(27'h0000123, 1'b1, 32'h77AD5A5A, 1'b1);
        wr(27'h0000163, 32'h12345678, 4'b0011, 1'b0);
        rd(27'h0000163, 1'b0, 32'h77AD5A5A, 1'b1);
    endtask

    task automatic test_flush;
        int n;
        n = 0;
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        while (bus.busy === 1'b1 && n < 100) begin
            n++;
            bus.rden = (n == 1); bus.rda = 27'h0000123;
            if (n == 1) begin
                sb.push_back('{m: 1'b0, d: 32'h0, cd: 1'b0, id: rid});
                rid++;
            end
            bus.wr = 1'b1; bus.wra = 27'h0000124; bus.wrd = 32'hBAD0BAD0; bus.wrm = 4'hF; bus.clr = 1'b0;
            bus.flush = (n == 10);
            @(negedge clk);
        end
        bus.rden = 1'b0; bus.wr = 1'b0; bus.flush = 1'b0;
        checks++;
        if (n != 32) begin
            errors++;
            $display("FAIL flush_busy_cycles: got %0d, expected 32", n);
        end
        rd(27'h0000123, 1'b0, 32'h0, 1'b0);
        rd(27'h0000124, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_replace;
        wr(27'h0000023, 32'hC0DE0001, 4'hF, 1'b0);
        wr(27'h0000043, 32'hC0DE0002, 4'hF, 1'b0);
        wr(27'h0000063, 32'hC0DE0003, 4'hF, 1'b0);
        rd(27'h0000023, 1'b0, 32'h0, 1'b0);
        rd(27'h0000043, 1'b1, 32'hC0DE0002, 1'b1);
        rd(27'h0000063, 1'b1, 32'hC0DE0003, 1'b1);
        wr(27'h0000083, 32'hC0DE0004, 4'hF, 1'b0);
        rd(27'h0000043, 1'b0, 32'h0, 1'b0);
        rd(27'h0000063, 1'b1, 32'hC0DE0003, 1'b1);
        rd(27'h0000083, 1'b1, 32'hC0DE0004, 1'b1);
    endtask

    task automatic test_invalidate;
        wr(27'h00000E3, 32'hFFFFFFFF, 4'hF, 1'b1);
        rd(27'h00000E3, 1'b0, 32'h0, 1'b0);
        wr(27'h0000063, 32'hFFFFFFFF, 4'hF, 1'b1);
        rd(27'h0000063, 1'b0, 32'h0, 1'b0);
        rd(27'h0000083, 1'b1, 32'hC0DE0004, 1'b1);
        wr(27'h00000A3, 32'hC0DE0005, 4'hF, 1'b0);
        wr(27'h00000C3, 32'hC0DE0006, 4'hF, 1'b0);
        rd(27'h00000A3, 1'b0, 32'h0, 1'b0);
        rd(27'h0000083, 1'b1, 32'hC0DE0004, 1'b1);
        rd(27'h00000C3, 1'b1, 32'hC0DE0006, 1'b1);
    endtask

    task automatic test_collision;
        wr(27'h0000045, 32'h11111111, 4'hF, 1'b0);
        bus.wr = 1'b1; bus.wra = 27'h0000045; bus.wrd = 32'h22222222; bus.wrm = 4'hF; bus.clr = 1'b0;
        rd(27'h0000045, 1'b1, 32'h11111111, 1'b1);
        bus.wr = 1'b0;
        rd(27'h0000045, 1'b1, 32'h22222222, 1'b1);
    endtask

    task automatic test_back_to_back;
        rd(27'h0000083, 1'b1, 32'hC0DE0004, 1'b1);
        rd(27'h0000123, 1'b0, 32'hC0DE0004, 1'b1);
        rd(27'h0000045, 1'b1, 32'h22222222, 1'b1);
        @(negedge clk);
        checks++;
        if (bus.match !== 1'b1 || bus.rdd !== 32'h22222222) begin
            errors++;
            $display("FAIL idle_hold: match=%0b rdd=%h, expected 1 22222222", bus.match, bus.rdd);
        end
    endtask

    task automatic test_reset_mid;
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.match !== 1'b0 || bus.rdd !== 32'h0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_state: busy=%0b match=%0b rdd=%h, expected 1 0 00000000", bus.busy, bus.match, bus.rdd);
        end
        rst_n = 1'b1;
        count_busy("mid_reset");
        rd(27'h0000083, 1'b0, 32'h0, 1'b1);
        rd(27'h0000045, 1'b0, 32'h0, 1'b1);
    endtask

    initial begin
        bus.rda = '0; bus.rden = 1'b0; bus.wra = '0; bus.wrd = '0;
        bus.wr = 1'b0; bus.wrm = '0; bus.clr = 1'b0; bus.flush = 1'b0;
        test_reset;
        test_alloc_hit;
        test_partial;
        test_flush;
        test_replace;
        test_invalidate;
        test_collision;
        test_back_to_back;
        test_reset_mid;
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d reads never produced a result, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
